// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory request bus between the fetch PC sequencer and imem.
// The master side owns the fetch address and request; imem answers with ready.
interface fetch_pc_ctrl_if;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_ready;

  modport master (output pc, output imem_req, input imem_ready);
  modport slave  (input pc, input imem_req, output imem_ready);
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Next-PC sequencer: owns the fetch PC, drives the imem request and resolves
// EX-stage redirects and ECALL/EBREAK halts, generating the pipeline flush.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no fetch request
//   RUN   | fetching; redirects, halts and stalls resolved each cycle
//   HALT  | fetch stopped at the frozen pc until resume
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_pc_ctrl_if.master  imem,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             resume,
  output logic             if_valid,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        req_q;
  logic        halted_q;

  logic [6:0]  opcode;
  logic        dec_en;
  logic        jump;
  logic        branch_taken;
  logic        redirect;
  logic        halt_op;
  logic [31:0] target;
  logic        fetch_done;
  logic        unused_bits;

  assign opcode       = ex_inst[6:0];
  assign dec_en       = ex_valid && (state == RUN);
  assign jump         = dec_en && ((opcode == OP_JAL) || (opcode == OP_JALR));
  assign branch_taken = dec_en && (opcode == OP_BRANCH) && ex_taken;
  assign redirect     = jump || branch_taken;
  assign halt_op      = dec_en && (opcode == OP_SYSTEM) && !redirect;
  assign target       = {ex_target[31:2], 2'b00};

  // A redirect or halt drops whatever word imem returns this cycle.
  assign fetch_done   = (state == RUN) && !redirect && !halt_op && !stall
                        && imem.imem_ready;

  assign flush        = redirect || halt_op;
  assign if_valid     = fetch_done;
  assign imem.pc      = pc_q;
  assign imem.imem_req = req_q;
  assign halted       = halted_q;

  assign unused_bits  = ^{ex_inst[31:7], ex_target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      halted_q     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state    <= RUN;
          req_q    <= 1'b1;
          halted_q <= 1'b0;
        end
        RUN: begin
          if (redirect) begin
            pc_q         <= target;
            redirect_cnt <= redirect_cnt + CNT_W'(1);
          end else if (halt_op) begin
            pc_q     <= ex_pc + 32'd4;
            state    <= HALT;
            req_q    <= 1'b0;
            halted_q <= 1'b1;
          end else if (fetch_done) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        HALT: begin
          if (resume) begin
            state    <= RUN;
            req_q    <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          req_q    <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a rule-level reference model.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          CW     = 4;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BR   = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ECL  = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, ex_valid = 1'b0, ex_taken = 1'b0, resume = 1'b0;
  logic [31:0] ex_inst = NOP, ex_pc = '0, ex_target = '0;
  logic if_valid, flush, halted;
  logic [CW-1:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master),
    .stall(stall), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .resume(resume),
    .if_valid(if_valid), .flush(flush), .halted(halted),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ev;
    logic [31:0] inst, epc;
    logic        tk;
    logic [31:0] tgt;
    logic        rdy, rs;
    logic [31:0] e_pc;
    logic        e_req, e_ifv, e_fl, e_h;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic st, logic ev, logic [31:0] inst,
                              logic [31:0] epc, logic tk, logic [31:0] tgt,
                              logic rdy, logic rs, logic [31:0] p, logic rq,
                              logic iv, logic fl, logic h, logic [3:0] c);
    vec_t r;
    r.st = st; r.ev = ev; r.inst = inst; r.epc = epc; r.tk = tk; r.tgt = tgt;
    r.rdy = rdy; r.rs = rs; r.e_pc = p; r.e_req = rq; r.e_ifv = iv;
    r.e_fl = fl; r.e_h = h; r.e_cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic ev, input logic [31:0] inst,
                       input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input logic rdy, input logic rs);
    stall = st; ex_valid = ev; ex_inst = inst; ex_pc = epc; ex_taken = tk;
    ex_target = tgt; bus.imem_ready = rdy; resume = rs;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p, input logic rq,
                         input logic iv, input logic fl, input logic h,
                         input logic [3:0] c);
    chk({tag, " pc"}, bus.pc, p);
    chk({tag, " imem_req"}, {31'b0, bus.imem_req}, {31'b0, rq});
    chk({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, iv});
    chk({tag, " flush"}, {31'b0, flush}, {31'b0, fl});
    chk({tag, " halted"}, {31'b0, halted}, {31'b0, h});
    chk({tag, " redirect_cnt"}, {28'b0, redirect_cnt}, {28'b0, c});
  endtask

  // Reference model: architectural view of the sequencer.
  typedef enum int { M_BOOT, M_RUN, M_HALT } mstate_t;
  mstate_t     m_st;
  logic [31:0] m_pc;
  int          m_cnt;

  task automatic model_expect(output logic rq, output logic iv,
                              output logic fl, output logic h);
    logic [6:0] op = ex_inst[6:0];
    bit live = (m_st == M_RUN) && ex_valid;
    bit redir = live && (op == 7'h6F || op == 7'h67 || (op == 7'h63 && ex_taken));
    bit hlt = live && !redir && op == 7'h73;
    rq = (m_st == M_RUN);
    fl = redir || hlt;
    iv = (m_st == M_RUN) && !fl && !stall && bus.imem_ready;
    h  = (m_st == M_HALT);
  endtask

  task automatic model_step();
    logic [6:0] op = ex_inst[6:0];
    bit live = (m_st == M_RUN) && ex_valid;
    bit redir = live && (op == 7'h6F || op == 7'h67 || (op == 7'h63 && ex_taken));
    bit hlt = live && !redir && op == 7'h73;
    case (m_st)
      M_BOOT: m_st = M_RUN;
      M_HALT: if (resume) m_st = M_RUN;
      default: begin
        if (redir) begin
          m_pc = ex_target & 32'hFFFF_FFFC;
          m_cnt = (m_cnt + 1) % 16;
        end else if (hlt) begin
          m_pc = ex_pc + 32'd4;
          m_st = M_HALT;
        end else if (!stall && bus.imem_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end
    endcase
  endtask

  initial begin
    logic rq, iv, fl, h;
    logic [6:0] op;
    logic [6:0] others [4];
    others[0] = 7'h13; others[1] = 7'h33; others[2] = 7'h03; others[3] = 7'h23;

    tbl[0]  = mk(0,0,NOP,0,0,0,1,0,   32'h100,0,0,0,0,0);
    tbl[1]  = mk(0,0,NOP,0,0,0,1,0,   32'h100,1,1,0,0,0);
    tbl[2]  = mk(0,0,NOP,0,0,0,1,0,   32'h104,1,1,0,0,0);
    tbl[3]  = mk(0,0,NOP,0,0,0,1,0,   32'h108,1,1,0,0,0);
    tbl[4]  = mk(1,1,BR,0,1,32'h2002,1,0, 32'h10C,1,0,1,0,0);
    tbl[5]  = mk(0,1,NOP,0,0,0,1,0,   32'h2000,1,1,0,0,1);
    tbl[6]  = mk(0,1,JALR,0,0,32'h3001,1,0, 32'h2004,1,0,1,0,1);
    tbl[7]  = mk(0,1,BR,0,0,32'h5000,1,0, 32'h3000,1,1,0,0,2);
    tbl[8]  = mk(0,0,NOP,0,0,0,1,0,   32'h3004,1,1,0,0,2);
    tbl[9]  = mk(0,1,JAL,0,0,32'h40,1,0, 32'h3008,1,0,1,0,2);
    tbl[10] = mk(0,0,NOP,0,0,0,0,0,   32'h40,1,0,0,0,3);
    tbl[11] = mk(0,0,NOP,0,0,0,0,0,   32'h40,1,0,0,0,3);
    tbl[12] = mk(0,0,NOP,0,0,0,0,0,   32'h40,1,0,0,0,3);
    tbl[13] = mk(0,0,NOP,0,0,0,1,0,   32'h40,1,1,0,0,3);
    tbl[14] = mk(0,0,NOP,0,0,0,1,0,   32'h44,1,1,0,0,3);
    tbl[15] = mk(0,0,JAL,0,0,32'h900,1,0, 32'h48,1,1,0,0,3);
    tbl[16] = mk(0,1,ECL,32'h80,0,0,1,0, 32'h4C,1,0,1,0,3);
    tbl[17] = mk(0,1,JAL,0,0,32'h700,1,0, 32'h84,0,0,0,1,3);
    tbl[18] = mk(0,0,NOP,0,0,0,1,1,   32'h84,0,0,0,1,3);
    tbl[19] = mk(0,0,NOP,0,0,0,1,0,   32'h84,1,1,0,0,3);
    tbl[20] = mk(0,0,NOP,0,0,0,1,0,   32'h88,1,1,0,0,3);
    tbl[21] = mk(0,1,JAL,0,0,32'hFFFF_FFFF,1,0, 32'h8C,1,0,1,0,3);
    tbl[22] = mk(0,0,NOP,0,0,0,1,0,   32'hFFFF_FFFC,1,1,0,0,4);
    tbl[23] = mk(0,0,NOP,0,0,0,1,0,   32'h0,1,1,0,0,4);
    tbl[24] = mk(1,0,NOP,0,0,0,1,0,   32'h4,1,0,0,0,4);
    tbl[25] = mk(0,0,NOP,0,0,0,1,0,   32'h4,1,1,0,0,4);

    bus.imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 32'h100, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].st, tbl[i].ev, tbl[i].inst, tbl[i].epc, tbl[i].tk,
            tbl[i].tgt, tbl[i].rdy, tbl[i].rs);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_req, tbl[i].e_ifv,
              tbl[i].e_fl, tbl[i].e_h, tbl[i].e_cnt);
      @(negedge clk);
    end

    // 16 redirects: counter passes through 0 after 12 and returns to 4.
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, JAL, 0, 0, 32'h500 + 32'(i * 8), 1, 0);
      #1;
      chk($sformatf("wrap flush %0d", i), {31'b0, flush}, 32'd1);
      @(negedge clk);
      if (i == 11) chk("wrap cnt zero", {28'b0, redirect_cnt}, 32'd0);
    end
    drive(0, 0, NOP, 0, 0, 0, 1, 0);
    #1;
    chk("wrap cnt back", {28'b0, redirect_cnt}, 32'd4);
    chk("wrap last target", bus.pc, 32'h578);

    // Reset asserted asynchronously while halted.
    @(negedge clk);
    drive(0, 1, ECL, 32'h80, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, NOP, 0, 0, 0, 1, 0);
    #1;
    chk("pre-reset halted", {31'b0, halted}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("midhalt reset", 32'h100, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    m_st = M_BOOT; m_pc = RST_PC; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: op = 7'h63;
        1: op = 7'h6F;
        2: op = 7'h67;
        3: op = 7'h73;
        default: op = others[$urandom_range(0, 3)];
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            {$urandom() & 32'hFFFF_FF80} | {25'b0, op}, $urandom(),
            $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3);
      #1;
      model_expect(rq, iv, fl, h);
      chk_all($sformatf("rand%0d", n), m_pc, rq, iv, fl, h, 4'(m_cnt));
      model_step();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
